// File: rtl/control_suma_por_nibbles.sv
// Nibble-serial adder sequencer: drives one external 4-bit adder, LS nibble first, registered carry.
// Optional subtract mode (A - B) when CTRL_SUMA_RESTA_EN is defined.
module control_suma_por_nibbles #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inicio,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 acarreo_entrada,
    output logic                 ocupado,
    output logic                 listo,
    output logic [4*NIBBLES-1:0] suma,
    output logic                 acarreo_salida,
    output logic [3:0]           ad_a,
    output logic [3:0]           ad_b,
    output logic                 ad_cin,
    input  logic [3:0]           ad_s,
    input  logic                 ad_cout
`ifdef CTRL_SUMA_RESTA_EN
    ,
    input  logic                 resta
`endif
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_ULTIMO = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        SUMA   = 2'd1,
        FIN    = 2'd2
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     suma_q, suma_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             acarreo_q, acarreo_d;
    logic             cout_q, cout_d;

    logic [W-1:0]     b_carga;
    logic             cin_carga;

    // Subtraction is A + ~B + 1; the stored carry then means "no borrow".
    always_comb begin
`ifdef CTRL_SUMA_RESTA_EN
        b_carga   = resta ? ~B : B;
        cin_carga = resta ? 1'b1 : acarreo_entrada;
`else
        b_carga   = B;
        cin_carga = acarreo_entrada;
`endif
    end

    always_comb begin
        estado_d  = estado_q;
        a_d       = a_q;
        b_d       = b_q;
        suma_d    = suma_q;
        idx_d     = idx_q;
        acarreo_d = acarreo_q;
        cout_d    = cout_q;

        case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    estado_d  = SUMA;
                    a_d       = A;
                    b_d       = b_carga;
                    acarreo_d = cin_carga;
                    idx_d     = '0;
                end
            end
            SUMA: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        suma_d[4*i +: 4] = ad_s;
                    end
                end
                acarreo_d = ad_cout;
                if (idx_q == IDX_ULTIMO) begin
                    estado_d = FIN;
                    idx_d    = '0;
                    cout_d   = ad_cout;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            FIN: begin
                estado_d = REPOSO;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q  <= REPOSO;
            a_q       <= '0;
            b_q       <= '0;
            suma_q    <= '0;
            idx_q     <= '0;
            acarreo_q <= 1'b0;
            cout_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            a_q       <= a_d;
            b_q       <= b_d;
            suma_q    <= suma_d;
            idx_q     <= idx_d;
            acarreo_q <= acarreo_d;
            cout_q    <= cout_d;
        end
    end

    // idx is held at 0 outside SUMA, so the adder sees nibble 0 when idle.
    always_comb begin
        ad_a = a_q[3:0];
        ad_b = b_q[3:0];
        for (int i = 1; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                ad_a = a_q[4*i +: 4];
                ad_b = b_q[4*i +: 4];
            end
        end
    end

    assign ad_cin         = acarreo_q;
    assign ocupado        = (estado_q != REPOSO);
    assign listo          = (estado_q == FIN);
    assign suma           = suma_q;
    assign acarreo_salida = cout_q;

endmodule

// File: tb/tb_control_suma_por_nibbles.sv
// Bench for control_suma_por_nibbles (add-only build): behavioural 4-bit adder plus
// a cycle-level reference model based on a busy countdown and whole-word arithmetic.
module tb_control_suma_por_nibbles;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         inicio;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         acarreo_entrada;
    logic         ocupado;
    logic         listo;
    logic [W-1:0] suma;
    logic         acarreo_salida;
    logic [3:0]   ad_a;
    logic [3:0]   ad_b;
    logic         ad_cin;
    logic [3:0]   ad_s;
    logic         ad_cout;

    control_suma_por_nibbles #(.NIBBLES(N)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inicio          (inicio),
        .A               (A),
        .B               (B),
        .acarreo_entrada (acarreo_entrada),
        .ocupado         (ocupado),
        .listo           (listo),
        .suma            (suma),
        .acarreo_salida  (acarreo_salida),
        .ad_a            (ad_a),
        .ad_b            (ad_b),
        .ad_cin          (ad_cin),
        .ad_s            (ad_s),
        .ad_cout         (ad_cout)
    );

    // External 4-bit adder stand-in
    assign {ad_cout, ad_s} = {1'b0, ad_a} + {1'b0, ad_b} + {4'b0000, ad_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state: cnt = remaining busy cycles (0 = idle, 1 = listo cycle)
    int           cnt = 0;
    logic [W:0]   exp_res = '0;
    logic [W-1:0] cap_a = '0;
    logic [W-1:0] cap_b = '0;
    logic         cap_cin = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        assert (got === want)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        return W'($urandom);
    endfunction

    task automatic check_outputs();
        int          idx;
        logic [63:0] m;
        logic [63:0] part;
        chk("ocupado", 64'(ocupado), 64'(cnt != 0));
        chk("listo", 64'(listo), 64'(cnt == 1));
        if (cnt <= 1) begin
            chk("suma", 64'(suma), 64'(exp_res[W-1:0]));
            chk("acarreo_salida", 64'(acarreo_salida), 64'(exp_res[W]));
            chk("ad_a_idle", 64'(ad_a), 64'(cap_a[3:0]));
            chk("ad_b_idle", 64'(ad_b), 64'(cap_b[3:0]));
            chk("ad_cin_idle", 64'(ad_cin), 64'(exp_res[W]));
        end else begin
            idx  = N + 1 - cnt;
            m    = (64'd1 << (4 * idx)) - 64'd1;
            part = (64'(cap_a) & m) + (64'(cap_b) & m) + 64'(cap_cin);
            chk("ad_a_slice", 64'(ad_a), 64'(cap_a[4*idx +: 4]));
            chk("ad_b_slice", 64'(ad_b), 64'(cap_b[4*idx +: 4]));
            chk("ad_cin_slice", 64'(ad_cin), 64'(part[4*idx]));
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check mid-cycle.
    task automatic step(input logic rst_v, input logic ini, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci);
        rst_n           = rst_v;
        inicio          = ini;
        A               = a;
        B               = b;
        acarreo_entrada = ci;
        @(posedge clk);
        if (!rst_v) begin
            cnt     = 0;
            exp_res = '0;
            cap_a   = '0;
            cap_b   = '0;
            cap_cin = 1'b0;
        end else if (cnt == 0) begin
            if (ini) begin
                cap_a   = a;
                cap_b   = b;
                cap_cin = ci;
                exp_res = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
                cnt     = N + 1;
            end
        end else begin
            cnt--;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, rnd_w(), rnd_w(), 1'($urandom));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        step(1'b1, 1'b1, a, b, ci);
        // inputs and inicio wiggle while busy; the result must not notice
        for (int i = 0; i < N + 1; i++) step(1'b1, 1'($urandom), rnd_w(), rnd_w(), 1'($urandom));
        idle_steps(1);
    endtask

    initial begin
        rst_n           = 1'b0;
        inicio          = 1'b0;
        A               = '0;
        B               = '0;
        acarreo_entrada = 1'b0;

        // Reset with garbage on the inputs
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rnd_w(), rnd_w(), 1'b1);
        idle_steps(2);

        // Directed: plain add, no carries
        step(1'b1, 1'b1, 16'h1234, 16'h4321, 1'b0);
        idle_steps(N);
        chk("listo_at_k_plus_5", 64'(listo), 64'd1);
        chk("dir1_suma", 64'(suma), 64'h5555);
        chk("dir1_cout", 64'(acarreo_salida), 64'd0);
        idle_steps(2);

        // Directed: full carry ripple through every slice
        run_op(16'hFFFF, 16'h0000, 1'b1);
        chk("dir2_suma", 64'(suma), 64'h0000);
        chk("dir2_cout", 64'(acarreo_salida), 64'd1);

        // Randomized operations with busy-time disturbance
        for (int t = 0; t < 12; t++) begin
            run_op(rnd_w(), rnd_w(), 1'($urandom));
            idle_steps(int'($urandom_range(0, 2)));
        end
        run_op(16'hFFFF, 16'hFFFF, 1'b1);

        // inicio held high with changing inputs: accepts every N+2 cycles
        for (int i = 0; i < 24; i++) step(1'b1, 1'b1, rnd_w(), rnd_w(), 1'($urandom));
        idle_steps(N + 2);

        // Reset during the third SUMA cycle aborts without listo
        step(1'b1, 1'b1, 16'hABCD, 16'h1357, 1'b1);
        step(1'b1, 1'b0, rnd_w(), rnd_w(), 1'b0);
        step(1'b1, 1'b0, rnd_w(), rnd_w(), 1'b0);
        step(1'b0, 1'b0, rnd_w(), rnd_w(), 1'b0);
        idle_steps(N + 3);

        // Recovery after the abort
        run_op(16'h8000, 16'h8000, 1'b0);
        run_op(rnd_w(), rnd_w(), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
